// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state type, default sizing and BCD helpers for the BCD timer
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_CLK_DIV  = 50000;
    localparam int DEF_TICK_DIV = 100;
    localparam int DEF_DIGITS   = 2;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Out-of-range presets (A..F) are clamped rather than left as illegal BCD.
    function automatic logic [3:0] bcd_sat(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/m_bcd_digit.sv
// rtl/m_bcd_digit.sv - one BCD decade with load/clear and up/down carry chaining
module m_bcd_digit
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic       clear,
    input  logic [3:0] load_val,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 4'd0;
        end else if (clear) begin
            q <= 4'd0;
        end else if (load) begin
            q <= bcd_sat(load_val);
        end else if (en && cin) begin
            if (up) begin
                q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
            end else begin
                q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
            end
        end
    end

    // Carry in up mode, borrow in down mode: this decade rolls over on the step.
    assign cout = cin & (up ? (q == BCD_MAX) : (q == 4'd0));

endmodule

// File: rtl/m_bcd_timer.sv
// rtl/m_bcd_timer.sv - prescaled BCD up/down seconds timer with run/pause/done control
module m_bcd_timer
    import timer_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int DIGITS   = DEF_DIGITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                mode,
    output logic [4*DIGITS-1:0] bcd,
    output logic [9:0]          sec_onehot,
    output logic                running,
    output logic                sec_tick,
    output logic                wrap,
    output logic                expired
);

    localparam int PRE1_W = $clog2(CLK_DIV);
    localparam int PRE2_W = $clog2(TICK_DIV);
    localparam logic [PRE1_W-1:0]   PRE1_TERM = PRE1_W'(CLK_DIV - 1);
    localparam logic [PRE2_W-1:0]   PRE2_TERM = PRE2_W'(TICK_DIV - 1);
    localparam logic [4*DIGITS-1:0] BCD_ONE   = (4*DIGITS)'(1);

    state_t              state, state_nx;
    logic [PRE1_W-1:0]   pre1;
    logic [PRE2_W-1:0]   pre2;
    logic                mode_q;
    logic                pre1_term, pre2_term;
    logic                bcd_zero, bcd_one;
    logic                do_clear, do_load, count_en, do_update, mode_set, zero_expire;
    logic [DIGITS:0]     carry;

    assign pre1_term = (pre1 == PRE1_TERM);
    assign pre2_term = (pre2 == PRE2_TERM);
    assign bcd_zero  = (bcd == '0);
    assign bcd_one   = (bcd == BCD_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        do_clear    = 1'b0;
        do_load     = 1'b0;
        count_en    = 1'b0;
        do_update   = 1'b0;
        mode_set    = 1'b0;
        zero_expire = 1'b0;
        if (clear) begin
            do_clear = 1'b1;
            state_nx = ST_IDLE;
        end else if (load && (state != ST_RUN)) begin
            do_load  = 1'b1;
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    // stop outranks start, so both together leave the timer idle
                    if (start && !stop) begin
                        mode_set = 1'b1;
                        if (mode && bcd_zero) begin
                            state_nx    = ST_DONE;
                            zero_expire = 1'b1;
                        end else begin
                            state_nx = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_nx = ST_IDLE;
                    end else begin
                        count_en = 1'b1;
                        if (pre1_term && pre2_term) begin
                            do_update = 1'b1;
                            if (mode_q && bcd_one) begin
                                state_nx = ST_DONE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre1 <= '0;
            pre2 <= '0;
        end else if (do_clear || do_load) begin
            pre1 <= '0;
            pre2 <= '0;
        end else if (count_en) begin
            pre1 <= pre1_term ? '0 : pre1 + 1'b1;
            if (pre1_term) begin
                pre2 <= pre2_term ? '0 : pre2 + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= 1'b0;
            running  <= 1'b0;
            sec_tick <= 1'b0;
            wrap     <= 1'b0;
            expired  <= 1'b0;
        end else begin
            if (mode_set) begin
                mode_q <= mode;
            end
            running  <= (state_nx == ST_RUN);
            sec_tick <= do_update;
            wrap     <= do_update & ~mode_q & carry[DIGITS];
            expired  <= (do_update & mode_q & bcd_one) | zero_expire;
        end
    end

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        m_bcd_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .en       (do_update),
            .up       (~mode_q),
            .load     (do_load),
            .clear    (do_clear),
            .load_val (load_val[4*i +: 4]),
            .cin      (carry[i]),
            .q        (bcd[4*i +: 4]),
            .cout     (carry[i+1])
        );
    end

    always_comb begin
        sec_onehot = '0;
        for (int k = 0; k < 10; k++) begin
            sec_onehot[k] = (bcd[3:0] == 4'(k));
        end
    end

endmodule

// File: tb/tb_m_bcd_timer.sv
// tb/tb_m_bcd_timer.sv - random and scenario stimulus against a decimal reference model
module tb_m_bcd_timer;

    localparam int CD  = 4;
    localparam int TD  = 3;
    localparam int DG  = 2;
    localparam int SEC = CD * TD;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, clear, load, mode;
    logic [4*DG-1:0] load_val;
    logic [4*DG-1:0] bcd;
    logic [9:0]    sec_onehot;
    logic          running, sec_tick, wrap, expired;

    int n_vec = 0;
    int n_bad = 0;

    int m_st, m_cnt, m_ph;
    bit m_mode, m_tick, m_wrap, m_exp;

    m_bcd_timer #(.CLK_DIV(CD), .TICK_DIV(TD), .DIGITS(DG)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .load       (load),
        .load_val   (load_val),
        .mode       (mode),
        .bcd        (bcd),
        .sec_onehot (sec_onehot),
        .running    (running),
        .sec_tick   (sec_tick),
        .wrap       (wrap),
        .expired    (expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int preset_value(input logic [7:0] v);
        int hi, lo;
        hi = (int'(v[7:4]) > 9) ? 9 : int'(v[7:4]);
        lo = (int'(v[3:0]) > 9) ? 9 : int'(v[3:0]);
        return hi * 10 + lo;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_cnt = 0; m_ph = 0; m_mode = 0;
        m_tick = 0; m_wrap = 0; m_exp = 0;
    endtask

    // Decimal count plus a single phase counter covering one whole second.
    task automatic model_step();
        m_tick = 0; m_wrap = 0; m_exp = 0;
        if (clear) begin
            m_cnt = 0; m_ph = 0; m_st = M_IDLE;
        end else if (load && m_st != M_RUN) begin
            m_cnt = preset_value(load_val); m_ph = 0; m_st = M_IDLE;
        end else if (m_st == M_IDLE) begin
            if (start && !stop) begin
                m_mode = mode;
                if (mode && m_cnt == 0) begin
                    m_st = M_DONE; m_exp = 1;
                end else begin
                    m_st = M_RUN;
                end
            end
        end else if (m_st == M_RUN) begin
            if (stop) begin
                m_st = M_IDLE;
            end else begin
                m_ph++;
                if (m_ph == SEC) begin
                    m_ph = 0; m_tick = 1;
                    if (!m_mode) begin
                        if (m_cnt == 99) m_wrap = 1;
                        m_cnt = (m_cnt + 1) % 100;
                    end else begin
                        m_cnt = m_cnt - 1;
                        if (m_cnt == 0) begin
                            m_exp = 1; m_st = M_DONE;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] eb;
        eb = {4'(m_cnt / 10), 4'(m_cnt % 10)};
        check("bcd", 32'(bcd), 32'(eb));
        check("sec_onehot", 32'(sec_onehot), 32'(10'b1 << (m_cnt % 10)));
        check("running", 32'(running), 32'(m_st == M_RUN));
        check("sec_tick", 32'(sec_tick), 32'(m_tick));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("expired", 32'(expired), 32'(m_exp));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input bit st, input bit sp, input bit cl, input bit ld,
                         input bit md, input logic [7:0] lv);
        start = st; stop = sp; clear = cl; load = ld; mode = md; load_val = lv;
    endtask

    initial begin
        int waited;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_onehot", 32'(sec_onehot), 32'h001);
        rst = 1'b0;

        // Up count from cleared
        drive(0, 0, 1, 0, 0, 8'h00); step();
        drive(1, 0, 0, 0, 0, 8'h00); step();
        for (int i = 1; i <= 3 * SEC; i++) begin
            step();
            if (i % SEC == 0) begin
                check("up_tick", 32'(sec_tick), 32'h1);
                check("up_bcd", 32'(bcd), 32'(i / SEC));
            end
        end

        // Wrap from 99
        drive(0, 0, 1, 0, 0, 8'h00); step();
        drive(0, 0, 0, 1, 0, 8'h99); step();
        drive(1, 0, 0, 0, 0, 8'h00); step();
        drive(0, 0, 0, 0, 0, 8'h00);
        for (int i = 1; i <= SEC; i++) step();
        check("wrap_bcd", 32'(bcd), 32'h00);
        check("wrap_pulse", 32'(wrap), 32'h1);
        check("wrap_tick", 32'(sec_tick), 32'h1);
        step();
        check("wrap_one_cycle", 32'(wrap), 32'h0);

        // Countdown to DONE, start ignored after
        drive(0, 0, 1, 0, 0, 8'h00); step();
        drive(0, 0, 0, 1, 0, 8'h02); step();
        drive(1, 0, 0, 0, 1, 8'h00); step();
        drive(0, 0, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 2 * SEC; i++) begin
            step();
            if (i == SEC) check("down_bcd1", 32'(bcd), 32'h01);
        end
        check("down_bcd0", 32'(bcd), 32'h00);
        check("down_expired", 32'(expired), 32'h1);
        check("down_running", 32'(running), 32'h0);
        drive(1, 0, 0, 0, 0, 8'h00);
        repeat (2 * SEC) step();
        check("done_holds", 32'(running), 32'h0);

        // Zero-start countdown goes straight to DONE
        drive(0, 0, 1, 0, 0, 8'h00); step();
        drive(1, 0, 0, 0, 1, 8'h00); step();
        check("zero_expired", 32'(expired), 32'h1);
        check("zero_no_tick", 32'(sec_tick), 32'h0);

        // Pause and resume mid-second
        drive(0, 0, 1, 0, 0, 8'h00); step();
        drive(1, 0, 0, 0, 0, 8'h00); step();
        drive(0, 0, 0, 0, 0, 8'h00);
        repeat (7) step();
        drive(0, 1, 0, 0, 0, 8'h00); step();
        drive(0, 0, 0, 0, 0, 8'h00);
        repeat (19) step();
        drive(1, 0, 0, 0, 0, 8'h00); step();
        drive(0, 0, 0, 0, 0, 8'h00);
        waited = 0;
        do begin
            step();
            waited++;
        end while (!sec_tick && waited < 3 * SEC);
        check("resume_latency", 32'(waited), 32'd5);

        // Priority and preset saturation
        drive(1, 0, 1, 1, 0, 8'h55); step();
        check("prio_bcd", 32'(bcd), 32'h00);
        check("prio_idle", 32'(running), 32'h0);
        drive(0, 0, 0, 1, 0, 8'hA7); step();
        check("sat_bcd", 32'(bcd), 32'h97);

        // Asynchronous reset mid-second
        drive(0, 0, 1, 0, 0, 8'h00); step();
        drive(1, 0, 0, 0, 0, 8'h00); step();
        drive(0, 0, 0, 0, 0, 8'h00);
        repeat (6) step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1 rst = 1'b0;
        compare_all();
        drive(1, 0, 0, 0, 0, 8'h00); step();
        drive(0, 0, 0, 0, 0, 8'h00);
        waited = 0;
        do begin
            step();
            waited++;
        end while (!sec_tick && waited < 3 * SEC);
        check("post_reset_latency", 32'(waited), 32'(SEC));

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 199) < 2, $urandom_range(0, 99) < 3,
                  1'($urandom_range(0, 1)), 8'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/m_bcd_timer.md
M_BCD_TIMER -- requirements
Module: m_bcd_timer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50000, giving clock cycles per prescale tick (legal range 2..65536).
REQ-002 The block SHALL have parameter TICK_DIV, default 100, giving prescale ticks per second (legal range 2..1024).
REQ-003 The block SHALL have parameter DIGITS, default 2, giving the number of BCD decades (legal range 1..6).
REQ-004 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port start, input, 1 bit: level-sampled request to run.
REQ-007 The block SHALL have port stop, input, 1 bit: pause request.
REQ-008 The block SHALL have port clear, input, 1 bit: zero the count and return to IDLE.
REQ-009 The block SHALL have port load, input, 1 bit: load load_val into the count.
REQ-010 The block SHALL have port load_val, input, 4*DIGITS bits: BCD preset, digit 0 in the LSBs.
REQ-011 The block SHALL have port mode, input, 1 bit: 0 = count up, 1 = count down.
REQ-012 The block SHALL have port bcd, output, 4*DIGITS bits: current count, BCD.
REQ-013 The block SHALL have port sec_onehot, output, 10 bits: one-hot decode of digit 0.
REQ-014 The block SHALL have port running, output, 1 bit: high in state RUN.
REQ-015 The block SHALL have port sec_tick, output, 1 bit: one-cycle pulse on each count update.
REQ-016 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when up-count wraps from all-9 to 0.
REQ-017 The block SHALL have port expired, output, 1 bit: one-cycle pulse when down-count reaches 0.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-019 Input priority SHALL be, per cycle: clear > load > stop > start.
REQ-020 clear SHALL act in any state and have this effect: bcd=0, both prescale counters=0, state IDLE, no pulse outputs.
REQ-021 load SHALL be honoured only in IDLE or DONE and have this effect: bcd=load_val, prescalers=0, state IDLE; any load_val digit above 9 is stored as 9.
REQ-022 In IDLE, start SHALL move the FSM to RUN and latch mode; mode changes during RUN SHALL be ignored.
REQ-023 In RUN, stop SHALL move the FSM to IDLE with bcd and both prescale counters held, so a later start resumes mid-second.
REQ-024 Only in RUN, the first prescale counter SHALL count 0..CLK_DIV-1 each cycle; at terminal it wraps to 0 and advances the second counter 0..TICK_DIV-1.
REQ-025 When both prescale counters are at terminal in the same cycle, bcd SHALL update on that same clock edge and sec_tick SHALL be high for exactly that cycle.
REQ-026 The first update after start from cleared prescalers SHALL occur CLK_DIV*TICK_DIV cycles after the start edge.
REQ-027 Up mode SHALL perform a BCD increment with decade carry; from all-9 the count becomes all-0, wrap pulses together with sec_tick, and the FSM stays in RUN.
REQ-028 Down mode SHALL perform a BCD decrement with borrow; when the result is 0, expired pulses together with sec_tick and the FSM enters DONE.
REQ-029 start in IDLE with mode=1 and bcd=0 SHALL enter DONE on the next edge, pulse expired for one cycle, and produce no sec_tick.
REQ-030 In DONE, start and stop SHALL be ignored; only clear or load leaves DONE.
REQ-031 sec_onehot[k] SHALL be high iff digit 0 equals k, combinationally from bcd.
REQ-032 running SHALL be a registered signal equal to (state==RUN).

Reset
REQ-033 rst SHALL force immediately: state IDLE, bcd=0, prescalers=0, running=0, sec_tick=0, wrap=0, expired=0, sec_onehot=10'b0000000001.
REQ-034 rst asserted mid-second SHALL discard partial prescale counts, with no pulse on release.

Structure
REQ-035 Package timer_pkg SHALL hold the FSM state enum, the default CLK_DIV/TICK_DIV/DIGITS constants, and the BCD digit-max constant 9.
REQ-036 One sub-module, m_bcd_digit, SHALL implement a single decade: enable, up/down, load, clear, carry/borrow in and out; it is instantiated DIGITS times in a chain.
REQ-037 Prescale counter widths SHALL be derived with $clog2 of the respective parameter.

Verification
REQ-038 The bench SHALL use CLK_DIV=4, TICK_DIV=3, DIGITS=2 so that 1 second = 12 cycles.
REQ-039 Up-count scenario: clear, then start held high -> sec_tick at cycles 12, 24, 36; bcd = 0x01, 0x02, 0x03.
REQ-040 Wrap scenario: load 0x99, mode=0, start -> at cycle 12 bcd=0x00 with wrap and sec_tick both high for 1 cycle.
REQ-041 Countdown scenario: load 0x02, mode=1, start -> bcd 0x01 at cycle 12, bcd 0x00 with expired at cycle 24, state DONE, running=0, and start ignored afterwards.
REQ-042 Pause scenario: start, stop at cycle 7, restart 20 cycles later -> next sec_tick 5 cycles after restart.
REQ-043 Priority/reset scenario: clear+load+start in the same cycle -> bcd=0, IDLE; load_val 0xA7 in IDLE -> bcd=0x97; rst pulse at cycle 6 of RUN -> all outputs at reset values at once, and the next tick 12 cycles after the next start.
